// File: rtl/mem_data_port_pkg.sv
// mem_data_port_pkg
// Shared definitions for the data-memory port: load-kind encodings, the
// port FSM state encoding, the bus wait limit and a zero word constant.
// Also holds the misalignment rule, used by the port when the
// MEM_ALIGN_CHECK_EN macro is defined.
package mem_data_port_pkg;

  // Load kinds as presented on the loadop input
  typedef enum logic [2:0] {
    NOP = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4,
    LW  = 3'd5
  } loadop_e;

  // Port FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0]  TIMEOUT_MAX = 8'd255;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

  // A load is judged by its kind; a store by its byte enables.
  // Halfwords need an even address, words need a word-aligned address.
  function automatic logic isMisaligned(input logic [1:0] addrLow,
                                        input logic [3:0] sel,
                                        input logic [2:0] op);
    logic bad;
    bad = 1'b0;
    if (op != NOP) begin
      if (op == LH || op == LHU) bad = addrLow[0];
      else if (op == LW)         bad = (addrLow != 2'b00);
    end else begin
      if (sel == 4'b0011 || sel == 4'b1100) bad = addrLow[0];
      else if (sel == 4'b1111)              bad = (addrLow != 2'b00);
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_extract.sv
// mem_load_extract
// Purely combinational load lane selection on a little-endian 32-bit word.
// Ports:
//   rdata  - word returned by the RAM
//   addr   - low two bits of the byte address of the load
//   loadop - load kind (NOP/LB/LBU/LH/LHU/LW)
//   word   - extracted, sign- or zero-extended writeback value
module mem_load_extract
  import mem_data_port_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  loadop,
  output logic [31:0] word
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Pick the addressed byte and halfword lane first, then extend it
  // according to the load kind. Unknown kinds produce zero.
  always_comb begin
    laneByte = rdata[7:0];
    case (addr)
      2'b00:   laneByte = rdata[7:0];
      2'b01:   laneByte = rdata[15:8];
      2'b10:   laneByte = rdata[23:16];
      default: laneByte = rdata[31:24];
    endcase
    laneHalf = addr[1] ? rdata[31:16] : rdata[15:0];

    word = ZERO_WORD;
    case (loadop)
      LB:      word = {{24{laneByte[7]}}, laneByte};
      LBU:     word = {24'h000000, laneByte};
      LH:      word = {{16{laneHalf[15]}}, laneHalf};
      LHU:     word = {16'h0000, laneHalf};
      LW:      word = rdata;
      default: word = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_data_port.sv
// mem_data_port
// Turns a single-cycle load/store request from the pipeline into a
// handshaked RAM transaction, stalling upstream until the access resolves.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned
// halfword/word accesses with an alignErr pulse instead of a bus access.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   memEnable         - request valid this cycle
//   ramAddr, ramSel   - byte address, store byte enables (0000 = not a store)
//   loadop            - load kind (NOP = not a load; load wins over store)
//   storeData         - store data, already lane-replicated
//   stallReq          - freeze upstream while the access is outstanding
//   result            - load writeback data (0 for stores and timeouts)
//   resultValid       - one-cycle strobe when an access completes
//   bus_req/we/addr/sel/wdata - RAM request, held stable until bus_ack
//   bus_rdata, bus_ack        - RAM response
//   busTimeout        - one-cycle strobe for an abandoned access
//   alignErr          - one-cycle strobe for a rejected misaligned access
module mem_data_port
  import mem_data_port_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        memEnable,
  input  logic [31:0] ramAddr,
  input  logic [3:0]  ramSel,
  input  logic [2:0]  loadop,
  input  logic [31:0] storeData,
  output logic        stallReq,
  output logic [31:0] result,
  output logic        resultValid,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        busTimeout,
  output logic        alignErr
);

  state_e      state, nextState;
  logic [31:0] addrReg, wdataReg, resultReg, loadWord;
  logic [3:0]  selReg;
  logic [2:0]  loadopReg;
  logic [7:0]  waitCount;
  logic        timeoutReg, alignErrReg;
  logic        reqLoad, reqStore, reqValid, reqMisaligned, accept;
  logic        busLoad, timeoutHit;

  assign reqLoad  = (loadop != NOP);
  assign reqStore = !reqLoad && (ramSel != 4'b0000);
  assign reqValid = memEnable && (reqLoad || reqStore);

`ifdef MEM_ALIGN_CHECK_EN
  assign reqMisaligned = isMisaligned(ramAddr[1:0], ramSel, loadop);
`else
  assign reqMisaligned = 1'b0;
`endif

  assign accept  = !rst && (state == IDLE) && reqValid && !reqMisaligned;
  assign busLoad = (loadopReg != NOP);

  // The wait counter reads N during the (N+1)th BUSY cycle, so seeing
  // TIMEOUT_MAX-1 without an ack means this is the last cycle we wait.
  // An ack in that same cycle still completes normally.
  assign timeoutHit = (state == BUSY) && !bus_ack &&
                      (waitCount == TIMEOUT_MAX - 8'd1);

  mem_load_extract u_extract (
    .rdata  (bus_rdata),
    .addr   (addrReg[1:0]),
    .loadop (loadopReg),
    .word   (loadWord)
  );

  // Next-state and output decode. Every output is forced low while rst is
  // high; the bus request is otherwise a pure function of BUSY and the
  // latched request, which keeps it stable until the ack.
  always_comb begin
    nextState = state;
    stallReq  = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = ZERO_WORD;
    bus_sel   = 4'b0000;
    bus_wdata = ZERO_WORD;
    case (state)
      IDLE: begin
        stallReq = accept;
        if (accept) nextState = BUSY;
      end
      BUSY: begin
        stallReq  = !rst;
        bus_req   = !rst;
        bus_we    = !rst && !busLoad;
        bus_addr  = rst ? ZERO_WORD : {addrReg[31:2], 2'b00};
        bus_sel   = rst ? 4'b0000 : (busLoad ? 4'b1111 : selReg);
        bus_wdata = (rst || busLoad) ? ZERO_WORD : wdataReg;
        if (bus_ack || timeoutHit) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign resultValid = !rst && (state == DONE);
  assign busTimeout  = !rst && timeoutReg;
  assign alignErr    = !rst && alignErrReg;
  assign result      = rst ? ZERO_WORD : resultReg;

  // State, request capture, wait counting and result update. A request
  // is latched only on acceptance, so anything presented in BUSY or DONE
  // has no effect. The timeout and alignment flags are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addrReg     <= ZERO_WORD;
      wdataReg    <= ZERO_WORD;
      selReg      <= 4'b0000;
      loadopReg   <= NOP;
      waitCount   <= 8'd0;
      resultReg   <= ZERO_WORD;
      timeoutReg  <= 1'b0;
      alignErrReg <= 1'b0;
    end else begin
      state       <= nextState;
      timeoutReg  <= 1'b0;
      alignErrReg <= (state == IDLE) && reqValid && reqMisaligned;
      if (accept) begin
        addrReg   <= ramAddr;
        selReg    <= ramSel;
        loadopReg <= loadop;
        wdataReg  <= storeData;
        waitCount <= 8'd0;
      end else if (state == BUSY) begin
        if (bus_ack) begin
          resultReg <= busLoad ? loadWord : ZERO_WORD;
        end else begin
          waitCount <= waitCount + 8'd1;
          if (timeoutHit) begin
            resultReg  <= ZERO_WORD;
            timeoutReg <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_data_port.sv
// tb_mem_data_port
// Bench for mem_data_port: a RAM responder with programmable ack latency,
// a scoreboard of expected completions, and a monitor that pops and
// compares whenever resultValid is seen. Build with MEM_ALIGN_CHECK_EN
// defined to exercise the alignment check.
module tb_mem_data_port;
  import mem_data_port_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        memEnable;
  logic [31:0] ramAddr;
  logic [3:0]  ramSel;
  logic [2:0]  loadop;
  logic [31:0] storeData;
  logic        stallReq;
  logic [31:0] result;
  logic        resultValid;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic        busTimeout, alignErr;

  typedef struct packed {
    logic [31:0] result;
    logic        timeout;
  } expect_t;

  expect_t     expQ[$];
  int          checks = 0;
  int          failures = 0;
  int          alignPending = 0;
  logic        busExpected = 1'b0;
  logic [68:0] expBus = '0;
  int          respLatency = 0;
  int          busyIdx = 0;
  logic        forceAck = 1'b0;
  logic [31:0] ramWord = '0;
  logic [31:0] lastResult = '0;

  mem_data_port dut (
    .clk         (clk),
    .rst         (rst),
    .memEnable   (memEnable),
    .ramAddr     (ramAddr),
    .ramSel      (ramSel),
    .loadop      (loadop),
    .storeData   (storeData),
    .stallReq    (stallReq),
    .result      (result),
    .resultValid (resultValid),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_sel     (bus_sel),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack),
    .busTimeout  (busTimeout),
    .alignErr    (alignErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [68:0] actual,
                             input logic [68:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference load: shift the addressed lane down and extend it
  function automatic logic [31:0] refLoad(input logic [31:0] w,
                                          input logic [31:0] a,
                                          input logic [2:0] op);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'h0000_00FF;
    h = (w >> (16 * a[1])) & 32'h0000_FFFF;
    case (op)
      3'd1:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      3'd5:    return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic refMisaligned(input logic [31:0] a, input logic [3:0] s,
                                         input logic [2:0] op);
    if (op == 3'd3 || op == 3'd4) return (a % 2) != 0;
    if (op == 3'd5)               return (a % 4) != 0;
    if (op != 3'd0)               return 1'b0;
    if (s == 4'b0011 || s == 4'b1100) return (a % 2) != 0;
    if (s == 4'b1111)                 return (a % 4) != 0;
    return 1'b0;
  endfunction

  // Issue one request, queue its expected completion and hold it until the
  // DUT signals completion (lat >= 255 means the RAM never acks).
  task automatic applyStimulus(input logic en, input logic [31:0] a,
                               input logic [3:0] s, input logic [2:0] op,
                               input logic [31:0] d, input logic [31:0] rdata,
                               input int lat);
    logic    isLoad, isStore, misal, issue, seen;
    int      stallCount, busyCycles;
    expect_t e;
    isLoad  = (op != 3'd0);
    isStore = !isLoad && (s != 4'b0000);
    misal   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal = refMisaligned(a, s, op);
`endif
    issue       = en && (isLoad || isStore) && !misal;
    ramWord     = rdata;
    respLatency = lat;
    busyCycles  = (lat >= 255) ? 255 : lat + 1;
    if (issue) begin
      if (isLoad) expBus = {1'b0, 4'b1111, a & 32'hFFFF_FFFC, 32'h0};
      else        expBus = {1'b1, s, a & 32'hFFFF_FFFC, d};
      e.timeout = (lat >= 255);
      e.result  = (isLoad && lat < 255) ? refLoad(rdata, a, op) : 32'h0;
      expQ.push_back(e);
      busExpected = 1'b1;
    end
    if (en && (isLoad || isStore) && misal) alignPending++;

    @(posedge clk); #1;
    memEnable = en; ramAddr = a; ramSel = s; loadop = op; storeData = d;
    #3;
    checkOutput("stall_accept", 69'(stallReq), 69'(issue));
    if (!issue) begin
      @(posedge clk); #1;
      memEnable = 1'b0;
      repeat (2) @(posedge clk);
      return;
    end
    stallCount = 0;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (resultValid) seen = 1'b1;
      else if (stallReq) stallCount++;
    end
    checkOutput("completion_seen", 69'(seen), 69'(1));
    if (seen) checkOutput("stall_cycles", 69'(stallCount), 69'(1 + busyCycles));
    @(posedge clk); #1;
    memEnable = 1'b0; loadop = 3'd0; ramSel = 4'b0000;
    busExpected = 1'b0;
  endtask

  // RAM responder: checks the request every BUSY cycle and acks after
  // respLatency extra cycles; forceAck drives a stray ack regardless.
  initial begin
    logic ackNow;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      ackNow = 1'b0;
      if (bus_req) begin
        if (!busExpected) checkOutput("bus_req_spurious", 69'(bus_req), 69'(0));
        else checkOutput("bus_fields", {bus_we, bus_sel, bus_addr, bus_wdata}, expBus);
        ackNow = (busyIdx == respLatency);
        busyIdx++;
      end else begin
        busyIdx = 0;
      end
      bus_ack   = ackNow || forceAck;
      bus_rdata = bus_ack ? ramWord : $urandom;
    end
  end

  // Monitor: pops the scoreboard on every completion and checks that
  // result holds between completions.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        lastResult = '0;
      end else begin
        if (resultValid) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_valid", 69'(resultValid), 69'(0));
          end else begin
            e = expQ.pop_front();
            checkOutput("result", 69'(result), 69'(e.result));
            checkOutput("busTimeout", 69'(busTimeout), 69'(e.timeout));
            lastResult = e.result;
          end
        end else begin
          checkOutput("result_hold", 69'(result), 69'(lastResult));
          if (busTimeout) checkOutput("stray_timeout", 69'(busTimeout), 69'(0));
        end
        if (alignErr) begin
          checkOutput("alignErr_expected", 69'(alignPending > 0), 69'(1));
          if (alignPending > 0) alignPending--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] selTable [8];
    selTable = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    // Reset with a live request on the inputs: nothing may leak out
    rst = 1'b1; memEnable = 1'b1; ramAddr = 32'h100; ramSel = 4'b0000;
    loadop = LW; storeData = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stallReq", 69'(stallReq), 69'(0));
    checkOutput("rst_bus", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata}, 69'(0));
    checkOutput("rst_result", 69'(result), 69'(0));
    checkOutput("rst_strobes", 69'({resultValid, busTimeout, alignErr}), 69'(0));
    @(posedge clk); #1;
    rst = 1'b0; memEnable = 1'b0; loadop = NOP;

    // Signed byte from the top lane, ack in the first BUSY cycle
    applyStimulus(1'b1, 32'h103, 4'b0000, LB,  32'h0, 32'h80FF_1234, 0);
    // Unsigned upper halfword
    applyStimulus(1'b1, 32'h102, 4'b0000, LHU, 32'h0, 32'h8001_0000, 1);
    // Byte store with three wait cycles
    applyStimulus(1'b1, 32'h206, 4'b0100, NOP, 32'hABAB_ABAB, 32'h1234_5678, 3);
    // Load wins over a nonzero sel
    applyStimulus(1'b1, 32'h301, 4'b1111, LH,  32'hFFFF_FFFF, 32'h0000_F00D, 2);
    // Timeout, then the ack arriving in the very last allowed cycle
    applyStimulus(1'b1, 32'h040, 4'b0000, LW,  32'h0, 32'hDEAD_BEEF, 1000);
    applyStimulus(1'b1, 32'h044, 4'b0000, LW,  32'h0, 32'hCAFE_F00D, 254);
    // Misaligned word load: rejected with the check, plain access without
    applyStimulus(1'b1, 32'h102, 4'b0000, LW,  32'h0, 32'h0BAD_F00D, 1);
    applyStimulus(1'b1, 32'h10, 4'b0000, NOP, 32'h0, 32'h0, 0);
    applyStimulus(1'b0, 32'h20, 4'b0000, LW,  32'h0, 32'h0, 0);

    // Reset in the middle of a transaction, then a late ack
    respLatency = 1000;
    busExpected = 1'b1;
    expBus = {1'b0, 4'b1111, 32'h300, 32'h0};
    @(posedge clk); #1;
    memEnable = 1'b1; loadop = LW; ramAddr = 32'h300; ramSel = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; memEnable = 1'b0; loadop = NOP;
    @(posedge clk); #1;
    busExpected = 1'b0;
    checkOutput("rst_mid_bus_req", 69'(bus_req), 69'(0));
    checkOutput("rst_mid_stall", 69'(stallReq), 69'(0));
    rst = 1'b0; forceAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("late_ack_valid", 69'(resultValid), 69'(0));
      checkOutput("late_ack_bus_req", 69'(bus_req), 69'(0));
    end
    @(posedge clk); #1;
    forceAck = 1'b0;
    repeat (2) @(posedge clk);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 7) != 0), $urandom & 32'h0000_0FFF,
                    selTable[$urandom_range(0, 7)], 3'($urandom_range(0, 5)),
                    $urandom, $urandom, $urandom_range(0, 5));
    end

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", 69'(expQ.size()), 69'(0));
    checkOutput("alignErr_drained", 69'(alignPending), 69'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_data_port.md
MEM_DATA_PORT -- requirements
Module: mem_data_port

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port memEnable, input, 1 bit: a memory-access request is presented this cycle.
REQ-004 SHALL have port ramAddr, input, 32 bits: byte address of the access.
REQ-005 SHALL have port ramSel, input, 4 bits: store byte enables; 0000 means not a store.
REQ-006 SHALL have port loadop, input, 3 bits: load kind, one of NOP, LB, LBU, LH, LHU, LW.
REQ-007 SHALL have port storeData, input, 32 bits: store data, already replicated across the byte lanes.
REQ-008 SHALL have port stallReq, output, 1 bit: freezes the upstream pipeline.
REQ-009 SHALL have port result, output, 32 bits: load writeback data.
REQ-010 SHALL have port resultValid, output, 1 bit: one-cycle strobe marking a completed access.
REQ-011 SHALL have ports bus_req (output, 1), bus_we (output, 1), bus_addr (output, 32), bus_sel (output, 4) and bus_wdata (output, 32): the RAM request.
REQ-012 SHALL have ports bus_rdata (input, 32) and bus_ack (input, 1): the RAM response.
REQ-013 SHALL have port busTimeout, output, 1 bit: one-cycle strobe marking an abandoned access.
REQ-014 SHALL have port alignErr, output, 1 bit: misalignment strobe (see Configuration).

Function
REQ-015 SHALL classify the request: loadop != NOP is a load; otherwise ramSel != 0 is a store; otherwise it is a no-op. Load SHALL win if both fields are set.
REQ-016 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-017 In IDLE, a load or store request with memEnable=1 SHALL be accepted:
- register the address, sel, loadop and data;
- go to BUSY;
- drive stallReq=1 combinationally in the acceptance cycle.
REQ-018 A no-op request, or memEnable=0, SHALL stay in IDLE with stallReq=0.
REQ-019 In BUSY the bus outputs SHALL be driven as follows:
- bus_req=1, bus_addr={addr[31:2],2'b00};
- loads: bus_we=0, bus_sel=1111, bus_wdata=0;
- stores: bus_we=1, bus_sel=ramSel, bus_wdata=storeData;
- all bus outputs held stable until bus_ack;
- stallReq=1.
REQ-020 bus_ack sampled in BUSY SHALL move to DONE. bus_ack may arrive in the first BUSY cycle (one-cycle RAM latency). bus_ack outside BUSY SHALL be ignored.
REQ-021 On the acknowledging edge, the load value SHALL be extracted from bus_rdata using little-endian lanes:
- LB/LBU: byte addr[1:0] (00 → bits 7:0, 11 → bits 31:24), sign- or zero-extended.
- LH/LHU: addr[1]=0 → bits 15:0, addr[1]=1 → bits 31:16, sign- or zero-extended.
- LW: the full word.
REQ-022 result SHALL be 0 for stores.
REQ-023 In DONE: resultValid=1, stallReq=0, result held, return to IDLE next cycle. result SHALL hold its value until the next completion.
REQ-024 An 8-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack. On reaching 255 the block SHALL:
- drop bus_req;
- pulse busTimeout;
- set result=0;
- go to DONE.
REQ-025 A request presented while in BUSY or DONE SHALL be ignored; upstream holds it because stallReq is asserted.

Reset
REQ-026 While rst=1, the following SHALL be forced:
- state=IDLE, counter=0;
- result=0;
- stallReq, resultValid, busTimeout, alignErr, bus_req, bus_we = 0;
- bus_addr, bus_sel, bus_wdata = 0.
REQ-027 Reset mid-transaction SHALL drop bus_req on the next edge. A late bus_ack for the dropped transaction SHALL be ignored.

Configuration
REQ-028 Macro MEM_ALIGN_CHECK_EN defined SHALL enable the alignment check. A request is misaligned if:
- LH/LHU/halfword store (sel 0011/1100) with addr[0]=1, or
- LW/word store (sel 1111) with addr[1:0]!=00.
REQ-029 A misaligned request SHALL issue no bus transaction, pulse alignErr for one cycle, keep stallReq=0 and stay in IDLE.
REQ-030 Without MEM_ALIGN_CHECK_EN, alignErr SHALL be tied to 0 and the address low bits SHALL only select lanes.

Structure
REQ-031 A shared package SHALL hold:
- the loadop encodings: NOP=0, LB=1, LBU=2, LH=3, LHU=4, LW=5;
- the FSM state encoding;
- TIMEOUT_MAX=255;
- ZERO_WORD.
REQ-032 Load extraction SHALL be one combinational sub-module, mem_load_extract (inputs: rdata, addr[1:0], loadop; output: word).

Verification
REQ-033 LB, addr 0x103, rdata 0x80FF_1234, ack 1 cycle after bus_req → result 0xFFFF_FF80, resultValid one cycle, stallReq high exactly 2 cycles.
REQ-034 LHU, addr 0x102, rdata 0x8001_0000 → result 0x0000_8001; bus_addr 0x100, bus_sel 1111, bus_we 0.
REQ-035 Store, sel 0100, data 0xABABABAB, addr 0x206, ack after 3 wait cycles → bus_we 1, bus_sel 0100, bus_addr 0x204, result 0, bus outputs stable throughout.
REQ-036 Load with no ack → busTimeout after 255 BUSY cycles, result 0, FSM returns to IDLE.
REQ-037 rst asserted during BUSY, then ack → bus_req 0 after the edge, no resultValid.
REQ-038 With MEM_ALIGN_CHECK_EN, LW at 0x102 → alignErr pulse, bus_req never asserted; without the macro → normal access at bus_addr 0x100.
